// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//
// 8N1 UART receiver, LSB first, using the same bit timing as the UartT
// transmitter. The asynchronous Rx line is synchronised first. A falling
// start edge is qualified at mid-bit, and each data bit is then sampled at
// mid-period. The stop bit is checked, and the byte goes into a one-entry
// holding register that the consumer empties with a valid/ack handshake.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   Rx_i         serial line, idle high, asynchronous to clk
//   ack_i        consumer has taken data_o (only meaningful while valid_o=1)
//   data_o       received byte, stable while valid_o=1, held after ack
//   valid_o      holding register full
//   frame_err_o  1-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    1-cycle pulse: good byte arrived while holding reg full
//   busy_o       receiver is inside a frame (state != IDLE)
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter logic [15:0] CLKS_PER_BIT = 16'd5210,
    parameter logic [15:0] HALF_BIT     = CLKS_PER_BIT >> 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Two-flop synchroniser. Both stages reset to the idle (high) level so
    // that reset does not look like a start edge.
    logic [1:0] sync_reg;
    logic       rx_s;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic        armed_reg, armed_next;
    logic [7:0]  data_reg, data_next;
    logic        valid_reg, valid_next;
    logic        frame_err_reg, frame_err_next;
    logic        overrun_reg, overrun_next;

    // Asserted for the single cycle in which the current data bit is captured.
    logic        sample_bit;
    logic [7:0]  shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], Rx_i};
        end
    end

    assign rx_s = sync_reg[1];

    // Shift register: each bit has its own enable and is written once per frame
    // when bit_idx points at it. Nothing shifts, so each bit lands directly at
    // its LSB-first position.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shreg
            logic bit_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    bit_reg <= 1'b0;
                end else if (sample_bit && (bit_idx_reg == 3'(gi))) begin
                    bit_reg <= rx_s;
                end
            end
            assign shreg[gi] = bit_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 16'd0;
            bit_idx_reg   <= 3'd0;
            armed_reg     <= 1'b0;
            data_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            armed_reg     <= armed_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        armed_next     = armed_reg;
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        sample_bit     = 1'b0;

        // The consumer empties the holding register. A stop evaluation in the
        // same cycle can refill it below.
        if (valid_reg && ack_i) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                // Arm only after the line has been seen high. This prevents
                // a held-low line (break, or the tail of a bad frame) from
                // retriggering a frame over and over.
                if (rx_s) begin
                    armed_next = 1'b1;
                end
                if (armed_reg && !rx_s) begin
                    state_next = START;
                    cnt_next   = 16'd0;
                    armed_next = 1'b0;
                end
            end

            START: begin
                if (cnt_reg == HALF_BIT - 16'd1) begin
                    if (!rx_s) begin
                        state_next   = DATA;
                        cnt_next     = 16'd0;
                        bit_idx_next = 3'd0;
                    end else begin
                        // The low level did not last to mid-bit, so treat it
                        // as a glitch.
                        state_next = IDLE;
                        cnt_next   = 16'd0;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            DATA: begin
                if (cnt_reg == CLKS_PER_BIT - 16'd1) begin
                    sample_bit   = 1'b1;
                    cnt_next     = 16'd0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            STOP: begin
                // Evaluate at mid-stop and return to IDLE at once. The half
                // bit that remains lets the next start edge of a back-to-back
                // frame be found.
                if (cnt_reg == CLKS_PER_BIT - 16'd1) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                    if (!rx_s) begin
                        frame_err_next = 1'b1;
                    end else if (!valid_reg || ack_i) begin
                        data_next  = shreg;
                        valid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase
    end

    assign data_o      = data_reg;
    assign valid_o     = valid_reg;
    assign frame_err_o = frame_err_reg;
    assign overrun_o   = overrun_reg;
    assign busy_o      = (state_reg != IDLE);

endmodule
